// File: rtl/ldr_pkg.sv
// Shared types and helpers for the load-execute unit: FSM states, load modes,
// and the byte-lane index width.
package ldr_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_WAIT = 3'b010,
    S_WB   = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    LD_WORD   = 2'd0,
    LD_BYTE_U = 2'd1,
    LD_BYTE_S = 2'd2
  } ld_mode_e;

  // Bits needed to pick one of DATA_W/8 byte lanes.
  function automatic int lane_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ldr_byte_lane.sv
// Big-endian byte-lane select with zero or sign extension to DATA_W.
module ldr_byte_lane
  import ldr_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LW     = lane_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [LW-1:0]     lane,
  input  logic              sext,
  output logic [DATA_W-1:0] byte_ext
);

  logic [7:0] sel;

  // Lane 0 is the most significant byte of the word.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < DATA_W / 8; i++) begin
      if (lane == LW'(i)) sel = data[DATA_W-1-8*i -: 8];
    end
    byte_ext = {{(DATA_W-8){sext & sel[7]}}, sel};
  end

endmodule

// File: rtl/instr_ldr_gen.sv
// Load-execute unit: base + offset address, one memory read, result (and
// optional base writeback) onto regbus3, with a memory-timeout watchdog.
module instr_ldr_gen
  import ldr_pkg::*;
#(
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter int          TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ldr,
  input  logic              ldrb,
  input  logic              sext,
  input  logic              wb,
  output logic              executeBusy,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] regbus2,
  output logic              r3we,
  output logic              r3sel,
  output logic [DATA_W-1:0] regbus3,
  output logic [ADDR_W-1:0] memory_address,
  input  logic [DATA_W-1:0] memory_data,
  output logic              memory_request,
  input  logic              memory_done,
  output logic              fault
);

  localparam int LW = lane_w(DATA_W);

  state_e            state, state_n;
  ld_mode_e          mode, mode_n;
  logic              wb_q, wb_n;
  logic [DATA_W-1:0] sum, sum_q, sum_n;
  logic [TO_W-1:0]   cnt, cnt_n;

  logic              busy_n, req_n, we_n, sel_n, fault_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] bus3_n, byte_val, loaded;

  assign sum = operand + regbus2;

  ldr_byte_lane #(.DATA_W(DATA_W), .LW(LW)) u_lane (
    .data     (memory_data),
    .lane     (sum_q[LW-1:0]),
    .sext     (mode == LD_BYTE_S),
    .byte_ext (byte_val)
  );

  assign loaded = (mode == LD_WORD) ? memory_data : byte_val;

  always_comb begin
    state_n = state;
    mode_n  = mode;
    wb_n    = wb_q;
    sum_n   = sum_q;
    cnt_n   = cnt;
    busy_n  = executeBusy;
    req_n   = memory_request;
    addr_n  = memory_address;
    we_n    = 1'b0;
    sel_n   = 1'b0;
    bus3_n  = '0;
    fault_n = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        req_n  = 1'b0;
        addr_n = '0;
        if (ldr || ldrb) begin
          state_n = S_WAIT;
          busy_n  = 1'b1;
          req_n   = 1'b1;
          addr_n  = sum[ADDR_W-1:0];
          mode_n  = ldr ? LD_WORD : (sext ? LD_BYTE_S : LD_BYTE_U);
          wb_n    = wb;
          sum_n   = sum;
          cnt_n   = '0;
        end
      end
      S_WAIT: begin
        // A done arriving in the timeout cycle still completes the load.
        if (memory_done) begin
          req_n   = 1'b0;
          addr_n  = '0;
          we_n    = 1'b1;
          bus3_n  = loaded;
          busy_n  = wb_q;
          state_n = wb_q ? S_WB : S_IDLE;
        end else if (TIMEOUT != 0 && cnt == TO_W'(TIMEOUT)) begin
          req_n   = 1'b0;
          addr_n  = '0;
          fault_n = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WB: begin
        we_n    = 1'b1;
        sel_n   = 1'b1;
        bus3_n  = sum_q;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
        req_n   = 1'b0;
        addr_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      mode           <= LD_WORD;
      wb_q           <= 1'b0;
      sum_q          <= '0;
      cnt            <= '0;
      executeBusy    <= 1'b0;
      memory_request <= 1'b0;
      memory_address <= '0;
      r3we           <= 1'b0;
      r3sel          <= 1'b0;
      regbus3        <= '0;
      fault          <= 1'b0;
    end else begin
      state          <= state_n;
      mode           <= mode_n;
      wb_q           <= wb_n;
      sum_q          <= sum_n;
      cnt            <= cnt_n;
      executeBusy    <= busy_n;
      memory_request <= req_n;
      memory_address <= addr_n;
      r3we           <= we_n;
      r3sel          <= sel_n;
      regbus3        <= bus3_n;
      fault          <= fault_n;
    end
  end

endmodule

// File: tb/tb_instr_ldr_gen.sv
// Randomised self-checking bench for instr_ldr_gen (16-bit and 32-bit instances).
module tb_instr_ldr_gen;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ldr = 0, ldrb = 0, sext = 0, wb = 0, mdone = 0;
  logic [15:0] operand = '0, regbus2 = '0, mdata = '0;
  logic        busy, r3we, r3sel, mreq, fault;
  logic [15:0] regbus3, maddr;

  logic        w_ldr = 0, w_ldrb = 0, w_sext = 0, w_wb = 0, w_mdone = 0;
  logic [31:0] w_operand = '0, w_regbus2 = '0, w_mdata = '0;
  logic        w_busy, w_r3we, w_r3sel, w_mreq, w_fault;
  logic [31:0] w_regbus3, w_maddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_ldr_gen #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .ldr(ldr), .ldrb(ldrb), .sext(sext), .wb(wb),
    .executeBusy(busy), .operand(operand), .regbus2(regbus2), .r3we(r3we),
    .r3sel(r3sel), .regbus3(regbus3), .memory_address(maddr), .memory_data(mdata),
    .memory_request(mreq), .memory_done(mdone), .fault(fault)
  );

  instr_ldr_gen #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO), .TO_W(8)) dut32 (
    .clk(clk), .reset(reset), .ldr(w_ldr), .ldrb(w_ldrb), .sext(w_sext), .wb(w_wb),
    .executeBusy(w_busy), .operand(w_operand), .regbus2(w_regbus2), .r3we(w_r3we),
    .r3sel(w_r3sel), .regbus3(w_regbus3), .memory_address(w_maddr), .memory_data(w_mdata),
    .memory_request(w_mreq), .memory_done(w_mdone), .fault(w_fault)
  );

  // Reference load result: byte n of a w-bit big-endian word sits n*8 bits below the top.
  function automatic logic [31:0] ref_load(input int w, input logic [31:0] data,
                                           input logic [31:0] addr, input bit is_byte,
                                           input bit sx);
    int lane, b;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    if (!is_byte) return data & mask;
    lane = int'(addr % (w / 8));
    b = int'((data >> (w - 8 * (lane + 1))) & 32'hFF);
    if (sx && b >= 128) b = b - 256;
    return 32'(b) & mask;
  endfunction

  task automatic test_reset();
    checks++;
    if ({mreq, busy, r3we, r3sel, fault} !== 5'b0 || maddr !== 16'h0 || regbus3 !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b busy=%b we=%b sel=%b fault=%b addr=%h bus3=%h exp all 0",
               mreq, busy, r3we, r3sel, fault, maddr, regbus3);
    end
  endtask

  // Entered and left on a negedge; dly = WAIT cycles before done is presented.
  task automatic run16(input bit c_ldr, input bit c_ldrb, input bit sx, input bit wbv,
                       input logic [15:0] base, input logic [15:0] off, input int dly,
                       input logic [15:0] data, input string tag);
    logic [15:0] s, expd;
    s = 16'((32'(base) + 32'(off)) % 65536);
    expd = 16'(ref_load(16, {16'h0, data}, {16'h0, s}, !c_ldr && c_ldrb, sx));
    ldr = c_ldr; ldrb = c_ldrb; sext = sx; wb = wbv; regbus2 = base; operand = off;
    @(negedge clk);
    ldr = 0; ldrb = 0; sext = 1'($urandom); wb = 1'($urandom);
    regbus2 = 16'($urandom); operand = 16'($urandom);
    checks++;
    if (mreq !== 1'b1 || maddr !== s || busy !== 1'b1 || r3we !== 1'b0) begin
      errors++;
      $display("FAIL %s issue got req=%b addr=%h busy=%b we=%b exp 1 %h 1 0", tag, mreq, maddr, busy, r3we, s);
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      checks++;
      if (mreq !== 1'b1 || r3we !== 1'b0 || fault !== 1'b0) begin
        errors++;
        $display("FAIL %s wait%0d got req=%b we=%b fault=%b exp 1 0 0", tag, i, mreq, r3we, fault);
      end
    end
    mdone = 1; mdata = data;
    @(negedge clk);
    mdone = 0; mdata = 16'($urandom);
    checks++;
    if (r3we !== 1'b1 || r3sel !== 1'b0 || regbus3 !== expd || mreq !== 1'b0 || maddr !== 16'h0 ||
        busy !== wbv || fault !== 1'b0) begin
      errors++;
      $display("FAIL %s data got we=%b sel=%b bus3=%h req=%b addr=%h busy=%b fault=%b exp 1 0 %h 0 0 %b 0",
               tag, r3we, r3sel, regbus3, mreq, maddr, busy, fault, expd, wbv);
    end
    if (wbv) begin
      @(negedge clk);
      checks++;
      if (r3we !== 1'b1 || r3sel !== 1'b1 || regbus3 !== s || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s writeback got we=%b sel=%b bus3=%h busy=%b exp 1 1 %h 0", tag, r3we, r3sel, regbus3, busy, s);
      end
    end
    @(negedge clk);
    checks++;
    if (r3we !== 1'b0 || regbus3 !== 16'h0 || busy !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got we=%b bus3=%h busy=%b fault=%b exp 0 0 0 0", tag, r3we, regbus3, busy, fault);
    end
  endtask

  task automatic test_directed();
    run16(1, 0, 0, 0, 16'h1000, 16'h0004, 3, 16'hBEEF, "word");
    run16(0, 1, 0, 0, 16'h2000, 16'h0000, 1, 16'h80F1, "byte0u");
    run16(0, 1, 0, 0, 16'h2000, 16'h0001, 2, 16'h80F1, "byte1u");
    run16(0, 1, 1, 0, 16'h1FFF, 16'h0001, 0, 16'h80F1, "byte0s");
    run16(0, 1, 1, 0, 16'h2001, 16'h0000, 4, 16'h80F1, "byte1s");
    run16(1, 0, 0, 1, 16'hFFFE, 16'h0004, 2, 16'h1234, "wb_wrap");
    run16(1, 1, 1, 0, 16'h3001, 16'h0000, 1, 16'hA5C3, "ldr_wins");
    run16(1, 0, 0, 0, 16'h4000, 16'h0002, TO, 16'h5A5A, "done_at_timeout");
  endtask

  task automatic test_timeout();
    ldr = 1; regbus2 = 16'h0100; operand = 16'h0010;
    @(negedge clk);
    ldr = 0;
    for (int i = 0; i <= TO; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (mreq !== 1'b1 || busy !== 1'b1 || fault !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait%0d got req=%b busy=%b fault=%b exp 1 1 0", i, mreq, busy, fault);
      end
    end
    @(negedge clk);
    checks++;
    if (mreq !== 1'b0 || fault !== 1'b1 || busy !== 1'b0 || r3we !== 1'b0 || maddr !== 16'h0) begin
      errors++;
      $display("FAIL timeout_fire got req=%b fault=%b busy=%b we=%b addr=%h exp 0 1 0 0 0", mreq, fault, busy, r3we, maddr);
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b0 || r3we !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got fault=%b we=%b exp 0 0", fault, r3we);
    end
  endtask

  task automatic test_busy_ignore();
    ldr = 1; regbus2 = 16'h0500; operand = 16'h0006;
    @(negedge clk);
    ldr = 0; ldrb = 1; operand = 16'h0777;
    @(negedge clk);
    ldrb = 0;
    checks++;
    if (maddr !== 16'h0506 || mreq !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore_addr got addr=%h req=%b exp 0506 1", maddr, mreq);
    end
    mdone = 1; mdata = 16'hC0DE;
    @(negedge clk);
    mdone = 0;
    checks++;
    if (r3we !== 1'b1 || regbus3 !== 16'hC0DE || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_data got we=%b bus3=%h busy=%b exp 1 c0de 0", r3we, regbus3, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    ldr = 1; regbus2 = 16'h0200; operand = 16'h0002;
    @(negedge clk);
    ldr = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({mreq, busy, r3we, r3sel, fault} !== 5'b0 || maddr !== 16'h0 || regbus3 !== 16'h0) begin
      errors++;
      $display("FAIL reset_abort got req=%b busy=%b we=%b sel=%b fault=%b addr=%h bus3=%h exp all 0",
               mreq, busy, r3we, r3sel, fault, maddr, regbus3);
    end
    reset = 0; mdone = 1; mdata = 16'hFFFF;
    @(negedge clk);
    mdone = 0;
    for (int i = 0; i < TO + 4; i++) begin
      checks++;
      if (r3we !== 1'b0 || fault !== 1'b0 || mreq !== 1'b0) begin
        errors++;
        $display("FAIL reset_after%0d got we=%b fault=%b req=%b exp 0 0 0", i, r3we, fault, mreq);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random16();
    for (int n = 0; n < 40; n++) begin
      logic c_ldr, c_ldrb;
      c_ldr = 1'($urandom);
      c_ldrb = c_ldr ? 1'($urandom) : 1'b1;
      run16(c_ldr, c_ldrb, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, TO)), 16'($urandom), "rand16");
    end
  endtask

  task automatic run32(input bit sx, input logic [31:0] base, input logic [31:0] off,
                       input int dly, input logic [31:0] data, input string tag);
    logic [31:0] s, expd;
    s = base + off;
    expd = ref_load(32, data, s, 1'b1, sx);
    w_ldrb = 1; w_sext = sx; w_regbus2 = base; w_operand = off;
    @(negedge clk);
    w_ldrb = 0; w_operand = $urandom;
    checks++;
    if (w_mreq !== 1'b1 || w_maddr !== s) begin
      errors++;
      $display("FAIL %s issue got req=%b addr=%h exp 1 %h", tag, w_mreq, w_maddr, s);
    end
    repeat (dly) @(negedge clk);
    w_mdone = 1; w_mdata = data;
    @(negedge clk);
    w_mdone = 0;
    checks++;
    if (w_r3we !== 1'b1 || w_regbus3 !== expd || w_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s data got we=%b bus3=%h busy=%b exp 1 %h 0", tag, w_r3we, w_regbus3, w_busy, expd);
    end
    @(negedge clk);
  endtask

  task automatic test_width32();
    run32(0, 32'h0000_1000, 32'h0000_0002, 2, 32'h1122_3344, "w32_lane2");
    run32(1, 32'h0000_1000, 32'h0000_0003, 0, 32'h1122_33C4, "w32_lane3s");
    for (int n = 0; n < 10; n++)
      run32(1'($urandom), $urandom, $urandom, int'($urandom_range(0, TO)), $urandom, "rand32");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    test_reset();
    test_directed();
    test_timeout();
    test_busy_ignore();
    test_reset_abort();
    test_random16();
    test_width32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
